// File: rtl/sr_ctrl_pkg.sv
// Shared definitions for the SR latch controller.
//   state_t   : controller FSM states
//   CNT_W     : width of the pulse/gap down-counter
//   idx_width : latch-index width, max(1, clog2(n))
package sr_ctrl_pkg;

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        PULSE,
        GAP
    } state_t;

    localparam int unsigned CNT_W = 4;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter.
//   clk, rst     : clock, asynchronous active-high reset
//   enable       : grants may be issued this cycle
//   req_a, req_b : request lines
//   advance      : a grant was taken this cycle; remember who won
//   gnt_a, gnt_b : combinational one-hot grants
// After reset B is recorded as the last winner, so A wins the first tie.
module rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic req_a,
    input  logic req_b,
    input  logic advance,
    output logic gnt_a,
    output logic gnt_b
);

    logic last_a;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_a <= 1'b0;
        end else if (advance) begin
            last_a <= gnt_a;
        end
    end

    always_comb begin
        gnt_a = enable & req_a & (~req_b | ~last_a);
        gnt_b = enable & req_b & (~req_a | last_a);
    end

endmodule

// File: rtl/sr_latch_arbiter.sv
// Arbitrates set/reset commands from two requesters onto a bank of
// downstream SR latches, generating fixed-width S/R pulses separated by gaps.
//   clk, rst               : clock, asynchronous active-high reset
//   a_valid/a_set/a_idx    : requester A command (set=1, reset=0, target latch)
//   a_ready                : requester A accepted this cycle (combinational)
//   b_*                    : same for requester B
//   s_out, r_out           : per-latch set/reset drive
//   q_mirror               : recorded latch states
//   busy                   : controller not in IDLE
module sr_latch_arbiter
    import sr_ctrl_pkg::*;
#(
    parameter  int unsigned N_LATCH = 4,
    parameter  int unsigned PULSE_W = 2,
    parameter  int unsigned GAP_W   = 1,
    localparam int unsigned IDX_W   = idx_width(N_LATCH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               a_valid,
    input  logic               a_set,
    input  logic [IDX_W-1:0]   a_idx,
    output logic               a_ready,
    input  logic               b_valid,
    input  logic               b_set,
    input  logic [IDX_W-1:0]   b_idx,
    output logic               b_ready,
    output logic [N_LATCH-1:0] s_out,
    output logic [N_LATCH-1:0] r_out,
    output logic [N_LATCH-1:0] q_mirror,
    output logic               busy
);

    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_W - 1);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               cmd_set;
    logic [IDX_W-1:0]   cmd_idx;

    logic               gnt_a;
    logic               gnt_b;
    logic               accept;
    logic               sel_set;
    logic [IDX_W-1:0]   sel_idx;
    logic               sel_in_range;
    logic               sel_redundant;
    logic [N_LATCH-1:0] sel_mask;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .enable  (state == IDLE),
        .req_a   (a_valid),
        .req_b   (b_valid),
        .advance (accept),
        .gnt_a   (gnt_a),
        .gnt_b   (gnt_b)
    );

    always_comb begin
        a_ready       = gnt_a;
        b_ready       = gnt_b;
        accept        = gnt_a | gnt_b;
        sel_set       = gnt_a ? a_set : b_set;
        sel_idx       = gnt_a ? a_idx : b_idx;
        sel_in_range  = int'(sel_idx) < int'(N_LATCH);
        sel_mask      = N_LATCH'(1) << sel_idx;
        sel_redundant = sel_in_range && (q_mirror[sel_idx] == sel_set);
        busy          = (state != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= INIT;
            cnt      <= PULSE_LOAD;
            s_out    <= '0;
            r_out    <= '0;
            q_mirror <= '0;
            cmd_set  <= 1'b0;
            cmd_idx  <= '0;
        end else begin
            case (state)
                INIT: begin
                    // r_out is still clear only on the first edge after reset;
                    // that edge starts the drive and the count runs from there.
                    if (r_out != '1) begin
                        r_out <= '1;
                    end else if (cnt == '0) begin
                        r_out <= '0;
                        cnt   <= GAP_LOAD;
                        state <= GAP;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                IDLE: begin
                    if (accept) begin
                        cmd_set <= sel_set;
                        cmd_idx <= sel_idx;
                        // Out-of-range and redundant commands are consumed silently.
                        if (sel_in_range && !sel_redundant) begin
                            state <= PULSE;
                            cnt   <= PULSE_LOAD;
                            if (sel_set) begin
                                s_out <= sel_mask;
                            end else begin
                                r_out <= sel_mask;
                            end
                        end
                    end
                end
                PULSE: begin
                    if (cnt == '0) begin
                        s_out             <= '0;
                        r_out             <= '0;
                        q_mirror[cmd_idx] <= cmd_set;
                        cnt               <= GAP_LOAD;
                        state             <= GAP;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                GAP: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sr_latch_arbiter.sv
// Directed bench for sr_latch_arbiter: expected pulses are queued when a
// command is driven and matched by a monitor when the DUT starts a pulse.
module tb_sr_latch_arbiter;

    localparam int unsigned N_LATCH = 4;
    localparam int unsigned PULSE_W = 2;
    localparam int unsigned GAP_W   = 1;

    logic       clk;
    logic       rst;
    logic       a_valid, a_set, a_ready;
    logic [1:0] a_idx;
    logic       b_valid, b_set, b_ready;
    logic [1:0] b_idx;
    logic [3:0] s_out, r_out, q_mirror;
    logic       busy;

    typedef struct {
        logic        set;
        int unsigned idx;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    sr_latch_arbiter #(
        .N_LATCH (N_LATCH),
        .PULSE_W (PULSE_W),
        .GAP_W   (GAP_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .a_valid  (a_valid),
        .a_set    (a_set),
        .a_idx    (a_idx),
        .a_ready  (a_ready),
        .b_valid  (b_valid),
        .b_set    (b_set),
        .b_idx    (b_idx),
        .b_ready  (b_ready),
        .s_out    (s_out),
        .r_out    (r_out),
        .q_mirror (q_mirror),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic push(input logic s, input int unsigned i);
        exp_t e;
        e.set = s;
        e.idx = i;
        exp_q.push_back(e);
    endtask

    // Pulse monitor and per-cycle invariants.
    logic [3:0] prev_sr = '0;
    int         width   = 0;

    always @(negedge clk) begin
        logic [3:0] sr;
        logic [3:0] ev;
        exp_t       e;
        if (rst) begin
            prev_sr = '0;
            width   = 0;
        end else begin
            sr = s_out | r_out;
            chk("s_r_overlap", 32'(s_out & r_out), 32'(0));
            chk("ready_while_busy", 32'(busy & (a_ready | b_ready)), 32'(0));
            if ($countones(sr) > 1) begin
                chk("multi_bit_outside_init", 32'({s_out, r_out}), 32'(8'h0F));
            end else if ($countones(sr) == 1) begin
                if (prev_sr == '0) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_pulse", 32'({s_out, r_out}), 32'(0));
                    end else begin
                        e  = exp_q.pop_front();
                        ev = 4'(1) << e.idx;
                        chk("pulse_s", 32'(s_out), 32'(e.set ? ev : 4'h0));
                        chk("pulse_r", 32'(r_out), 32'(e.set ? 4'h0 : ev));
                    end
                    width = 1;
                end else begin
                    width++;
                end
            end else if ($countones(prev_sr) == 1) begin
                chk("pulse_width", 32'(width), 32'(PULSE_W));
                width = 0;
            end
            prev_sr = sr;
        end
    end

    initial begin
        rst = 1'b1;
        a_valid = 1'b1; a_set = 1'b0; a_idx = '0;
        b_valid = 1'b0; b_set = 1'b0; b_idx = '0;

        // Reset values, with A requesting to show ready is withheld.
        step(); step(); #1;
        chk("rst_s_out", 32'(s_out), 32'(0));
        chk("rst_r_out", 32'(r_out), 32'(0));
        chk("rst_q", 32'(q_mirror), 32'(0));
        chk("rst_busy", 32'(busy), 32'(1));
        chk("rst_a_ready", 32'(a_ready), 32'(0));
        a_valid = 1'b0;

        // Reset release: 2 cycles of r_out all ones, 1 gap, then idle.
        step(); rst = 1'b0;
        step(); chk("init_r1", 32'(r_out), 32'(4'hF)); chk("init_busy", 32'(busy), 32'(1));
        step(); chk("init_r2", 32'(r_out), 32'(4'hF));
        step(); chk("init_gap_r", 32'(r_out), 32'(0)); chk("init_gap_busy", 32'(busy), 32'(1));
        step(); chk("idle_busy", 32'(busy), 32'(0)); chk("idle_q", 32'(q_mirror), 32'(0));

        // Both valid after reset: A (set 1) first, then B (set 3) by round robin.
        a_valid = 1'b1; a_set = 1'b1; a_idx = 2'd1;
        b_valid = 1'b1; b_set = 1'b1; b_idx = 2'd3;
        #1;
        chk("tie_a_ready", 32'(a_ready), 32'(1));
        chk("tie_b_ready", 32'(b_ready), 32'(0));
        push(1'b1, 1);
        step(); chk("a1_s_p1", 32'(s_out), 32'(4'b0010)); chk("a1_busy", 32'(busy), 32'(1));
        step(); chk("a1_s_p2", 32'(s_out), 32'(4'b0010));
        step(); chk("a1_s_gap", 32'(s_out), 32'(0)); chk("a1_q", 32'(q_mirror), 32'(4'b0010));
        step(); #1;
        chk("rr_b_ready", 32'(b_ready), 32'(1));
        chk("rr_a_ready", 32'(a_ready), 32'(0));
        push(1'b1, 3);
        step(); a_valid = 1'b0; b_valid = 1'b0;
        chk("b3_s_p1", 32'(s_out), 32'(4'b1000));
        step(); chk("b3_s_p2", 32'(s_out), 32'(4'b1000));
        step(); chk("b3_q", 32'(q_mirror), 32'(4'b1010));
        step(); chk("b3_busy", 32'(busy), 32'(0));

        // Redundant reset of latch 0: accepted, no pulse, stays idle.
        a_valid = 1'b1; a_set = 1'b0; a_idx = 2'd0;
        #1; chk("red_a_ready", 32'(a_ready), 32'(1));
        step(); a_valid = 1'b0;
        chk("red_busy1", 32'(busy), 32'(0)); chk("red_r1", 32'(r_out), 32'(0));
        step(); chk("red_busy2", 32'(busy), 32'(0)); chk("red_r2", 32'(r_out), 32'(0));

        // Pointer advanced on the redundant accept: B (reset 3) beats A (set 2).
        a_valid = 1'b1; a_set = 1'b1; a_idx = 2'd2;
        b_valid = 1'b1; b_set = 1'b0; b_idx = 2'd3;
        #1;
        chk("rr2_b_ready", 32'(b_ready), 32'(1));
        chk("rr2_a_ready", 32'(a_ready), 32'(0));
        push(1'b0, 3);
        step(); b_valid = 1'b0; b_idx = 2'd0;
        chk("b_r3_p1", 32'(r_out), 32'(4'b1000));
        step(); chk("b_r3_p2", 32'(r_out), 32'(4'b1000));
        step(); chk("b_r3_q", 32'(q_mirror), 32'(4'b0010));
        step(); #1; chk("a2_ready", 32'(a_ready), 32'(1));
        push(1'b1, 2);
        step(); a_valid = 1'b0; a_set = 1'b0; a_idx = 2'd0;
        chk("a2_ready_drop", 32'(a_ready), 32'(0));
        chk("a2_s_p1", 32'(s_out), 32'(4'b0100));
        step(); chk("a2_s_p2", 32'(s_out), 32'(4'b0100));
        step(); chk("a2_s_gap", 32'(s_out), 32'(0)); chk("a2_q", 32'(q_mirror), 32'(4'b0110));
        chk("a2_gap_busy", 32'(busy), 32'(1));
        step(); chk("a2_idle", 32'(busy), 32'(0));

        // Reset asserted in the second cycle of a set pulse on latch 0.
        a_valid = 1'b1; a_set = 1'b1; a_idx = 2'd0;
        #1; chk("a0_ready", 32'(a_ready), 32'(1));
        push(1'b1, 0);
        step(); a_valid = 1'b0;
        chk("a0_s_p1", 32'(s_out), 32'(4'b0001));
        step(); chk("a0_s_p2", 32'(s_out), 32'(4'b0001));
        rst = 1'b1;
        #1;
        chk("midrst_s", 32'(s_out), 32'(0));
        chk("midrst_q", 32'(q_mirror), 32'(0));
        chk("midrst_busy", 32'(busy), 32'(1));
        step(); rst = 1'b0;
        step(); chk("reinit_r1", 32'(r_out), 32'(4'hF));
        step(); chk("reinit_r2", 32'(r_out), 32'(4'hF));
        step(); chk("reinit_gap", 32'(r_out), 32'(0));
        step(); chk("reinit_idle", 32'(busy), 32'(0)); chk("reinit_q", 32'(q_mirror), 32'(0));

        // After reset A wins the tie again (redundant reset 2), then B sets 1.
        a_valid = 1'b1; a_set = 1'b0; a_idx = 2'd2;
        b_valid = 1'b1; b_set = 1'b1; b_idx = 2'd1;
        #1;
        chk("rst_rr_a", 32'(a_ready), 32'(1));
        chk("rst_rr_b", 32'(b_ready), 32'(0));
        step(); a_valid = 1'b0;
        chk("rst_red_busy", 32'(busy), 32'(0));
        #1; chk("b1_ready", 32'(b_ready), 32'(1));
        push(1'b1, 1);
        step(); b_valid = 1'b0;
        chk("b1_s_p1", 32'(s_out), 32'(4'b0010));
        step(); chk("b1_s_p2", 32'(s_out), 32'(4'b0010));
        step(); step(); chk("b1_q", 32'(q_mirror), 32'(4'b0010)); chk("b1_busy", 32'(busy), 32'(0));

        step(); step();
        chk("sb_empty", 32'(exp_q.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
